// File: rtl/screen_region_rmw_pkg.sv
// Shared graphics definitions for the screen-side read-modify-write stage:
// FSM state encoding and default screen/colour geometry.
package screen_region_rmw_pkg;

  localparam int DEFAULT_WIDTH        = 8;
  localparam int DEFAULT_COLOUR_WIDTH = 3;
  localparam int DEFAULT_SCREEN_W     = 160;
  localparam int DEFAULT_SCREEN_H     = 120;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_WAIT  = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } rmw_state_e;

endpackage

// File: rtl/screen_region_rmw_if.sv
// Rasteriser and framebuffer signals of the region RMW stage; slave = the stage itself,
// master = the rasteriser/framebuffer side. No backpressure: start/done is a four-phase handshake.
interface screen_region_rmw_if #(
  parameter int WIDTH        = 8,
  parameter int COLOUR_WIDTH = 3
);
  logic                    start;
  logic [WIDTH-1:0]        x_min;
  logic [WIDTH-1:0]        y_min;
  logic [WIDTH-1:0]        x_range;
  logic [WIDTH-1:0]        y_range;
  logic [COLOUR_WIDTH-1:0] new_colour;
  logic [WIDTH-1:0]        x;
  logic [WIDTH-1:0]        y;
  logic [COLOUR_WIDTH-1:0] old_colour;
  logic                    done;
  logic [WIDTH-1:0]        fb_rx;
  logic [WIDTH-1:0]        fb_ry;
  logic [COLOUR_WIDTH-1:0] fb_rdata;
  logic                    fb_we;
  logic [WIDTH-1:0]        fb_wx;
  logic [WIDTH-1:0]        fb_wy;
  logic [COLOUR_WIDTH-1:0] fb_wdata;

  modport slave (
    input  start, x_min, y_min, x_range, y_range, new_colour, fb_rdata,
    output x, y, old_colour, done, fb_rx, fb_ry, fb_we, fb_wx, fb_wy, fb_wdata
  );

  modport master (
    output start, x_min, y_min, x_range, y_range, new_colour, fb_rdata,
    input  x, y, old_colour, done, fb_rx, fb_ry, fb_we, fb_wx, fb_wy, fb_wdata
  );
endinterface

// File: rtl/screen_region_rmw_region_stepper.sv
// Row-major walker over a latched bounding box; x/y move one pixel per step, last flags the final pixel.
// Coordinates are kept one bit wider than WIDTH so a box running off the coordinate space never wraps.
module region_stepper
  import screen_region_rmw_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int SCREEN_W = DEFAULT_SCREEN_W,
  parameter int SCREEN_H = DEFAULT_SCREEN_H
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] x_min,
  input  logic [WIDTH-1:0] y_min,
  input  logic [WIDTH-1:0] x_range,
  input  logic [WIDTH-1:0] y_range,
  output logic [WIDTH-1:0] x,
  output logic [WIDTH-1:0] y,
  output logic             last,
  output logic             visible
);

  localparam logic [WIDTH:0] SCREEN_W_L = (WIDTH+1)'(SCREEN_W);
  localparam logic [WIDTH:0] SCREEN_H_L = (WIDTH+1)'(SCREEN_H);

  logic [WIDTH:0] x_q;
  logic [WIDTH:0] y_q;
  logic [WIDTH:0] x_start_q;
  logic [WIDTH:0] x_end_q;
  logic [WIDTH:0] y_end_q;
  logic           row_end;

  assign row_end = (x_q == x_end_q);

  always_ff @(posedge clock) begin
    if (reset) begin
      x_q       <= '0;
      y_q       <= '0;
      x_start_q <= '0;
      x_end_q   <= '0;
      y_end_q   <= '0;
    end else if (load) begin
      x_q       <= {1'b0, x_min};
      y_q       <= {1'b0, y_min};
      x_start_q <= {1'b0, x_min};
      x_end_q   <= {1'b0, x_min} + {1'b0, x_range};
      y_end_q   <= {1'b0, y_min} + {1'b0, y_range};
    end else if (step) begin
      if (row_end) begin
        x_q <= x_start_q;
        y_q <= y_q + 1'b1;
      end else begin
        x_q <= x_q + 1'b1;
      end
    end
  end

  assign last    = row_end && (y_q == y_end_q);
  // Wide compare: columns past 2^WIDTH-1 are simply off-screen, never aliased onto x = 0.
  assign visible = (x_q < SCREEN_W_L) && (y_q < SCREEN_H_L);
  assign x       = x_q[WIDTH-1:0];
  assign y       = y_q[WIDTH-1:0];

endmodule

// File: rtl/screen_region_rmw.sv
// Walks a latched box and read-modify-writes each on-screen pixel: 3 cycles per visible pixel, 1 per skipped one.
// No backpressure; framebuffer read is fixed 1-cycle latency, start/done is a four-phase level handshake.
module screen_region_rmw
  import screen_region_rmw_pkg::*;
#(
  parameter int WIDTH        = DEFAULT_WIDTH,
  parameter int COLOUR_WIDTH = DEFAULT_COLOUR_WIDTH,
  parameter int SCREEN_W     = DEFAULT_SCREEN_W,
  parameter int SCREEN_H     = DEFAULT_SCREEN_H
) (
  input  logic                clock,
  input  logic                reset,
  screen_region_rmw_if.slave  bus
);

  rmw_state_e              state_q;
  rmw_state_e              state_d;
  logic                    load;
  logic                    step;
  logic [WIDTH-1:0]        x_cur;
  logic [WIDTH-1:0]        y_cur;
  logic                    last;
  logic                    visible;
  logic [WIDTH-1:0]        rx_q;
  logic [WIDTH-1:0]        ry_q;
  logic                    we;
  logic                    done;
  logic [COLOUR_WIDTH-1:0] wdata;

  region_stepper #(
    .WIDTH    (WIDTH),
    .SCREEN_W (SCREEN_W),
    .SCREEN_H (SCREEN_H)
  ) u_stepper (
    .clock   (clock),
    .reset   (reset),
    .load    (load),
    .step    (step),
    .x_min   (bus.x_min),
    .y_min   (bus.y_min),
    .x_range (bus.x_range),
    .y_range (bus.y_range),
    .x       (x_cur),
    .y       (y_cur),
    .last    (last),
    .visible (visible)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Read address is registered in S_READ so the synchronous RAM returns data in S_WRITE.
  always_ff @(posedge clock) begin
    if (reset) begin
      rx_q <= '0;
      ry_q <= '0;
    end else if (state_q == S_READ && visible) begin
      rx_q <= x_cur;
      ry_q <= y_cur;
    end
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          load    = 1'b1;
          state_d = S_READ;
        end
      end
      S_READ: begin
        if (visible) begin
          state_d = S_WAIT;
        end else begin
          step    = 1'b1;
          state_d = last ? S_DONE : S_READ;
        end
      end
      S_WAIT: begin
        state_d = S_WRITE;
      end
      S_WRITE: begin
        step    = 1'b1;
        state_d = last ? S_DONE : S_READ;
      end
      S_DONE: begin
        if (!bus.start) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    we    = (state_q == S_WRITE);
    done  = (state_q == S_DONE);
    wdata = bus.new_colour;
  end

  assign bus.x          = x_cur;
  assign bus.y          = y_cur;
  assign bus.old_colour = bus.fb_rdata;
  assign bus.done       = done;
  assign bus.fb_rx      = rx_q;
  assign bus.fb_ry      = ry_q;
  assign bus.fb_we      = we;
  assign bus.fb_wx      = x_cur;
  assign bus.fb_wy      = y_cur;
  assign bus.fb_wdata   = wdata;

endmodule

// File: tb/tb_screen_region_rmw.sv
// Bench for screen_region_rmw: framebuffer and rasteriser models, directed box table, reset abort, random boxes.
module tb_screen_region_rmw;

  localparam int SW = 160;
  localparam int SH = 120;

  logic clock;
  logic reset;

  screen_region_rmw_if #(.WIDTH(8), .COLOUR_WIDTH(3)) bus ();

  screen_region_rmw #(
    .WIDTH        (8),
    .COLOUR_WIDTH (3),
    .SCREEN_W     (SW),
    .SCREEN_H     (SH)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int vectors;
  int miscompares;

  task automatic check(input string name, input int actual, input int expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Rasteriser colour rule, shared by the combinational stimulus and the reference model.
  int rast_mode;
  function automatic logic [2:0] raster(input int mode, input logic [7:0] px,
                                        input logic [7:0] py, input logic [2:0] old);
    if (mode == 0) return px[0] ? 3'b100 : old;
    return old ^ px[2:0] ^ {py[1:0], 1'b1};
  endfunction

  always_comb bus.new_colour = raster(rast_mode, bus.x, bus.y, bus.old_colour);

  function automatic logic [2:0] fill_val(input int i, input int j, input int sel, input int seed);
    int v;
    if (sel == 0) return 3'b001;
    v = (i * 5 + j * 3 + seed) & 7;
    return v[2:0];
  endfunction

  // Framebuffer model: synchronous read with one cycle latency, write on fb_we.
  logic [2:0] mem [0:255][0:255];
  logic       preload_req;
  int         preload_sel;
  int         preload_seed;

  always @(posedge clock) begin
    if (preload_req) begin
      for (int i = 0; i < 256; i++)
        for (int j = 0; j < 256; j++)
          mem[i][j] <= fill_val(i, j, preload_sel, preload_seed);
    end else begin
      bus.fb_rdata <= mem[bus.fb_rx][bus.fb_ry];
      if (bus.fb_we) mem[bus.fb_wx][bus.fb_wy] <= bus.fb_wdata;
    end
  end

  // Observed writes, packed as {x, y, old_colour, data}.
  int wq[$];
  always @(negedge clock) begin
    if (bus.fb_we === 1'b1)
      wq.push_back((int'(bus.fb_wx) << 16) | (int'(bus.fb_wy) << 6) |
                   (int'(bus.old_colour) << 3) | int'(bus.fb_wdata));
  end

  // Reference model state.
  logic [2:0] ref_mem [0:SW-1][0:SH-1];
  int         exp_q[$];

  task automatic do_preload(input int sel, input int seed);
    @(negedge clock);
    preload_sel  = sel;
    preload_seed = seed;
    preload_req  = 1'b1;
    @(negedge clock);
    preload_req  = 1'b0;
    for (int i = 0; i < SW; i++)
      for (int j = 0; j < SH; j++)
        ref_mem[i][j] = fill_val(i, j, sel, seed);
  endtask

  // Expected writes and start-to-done edge count, straight from the box walk rules.
  task automatic model_scan(input int xm, input int ym, input int xr, input int yr,
                            input int mode, output int cycles);
    logic [7:0] xb;
    logic [7:0] yb;
    logic [2:0] old;
    logic [2:0] nw;
    exp_q.delete();
    cycles = 1;
    for (int yy = ym; yy <= ym + yr; yy++) begin
      for (int xx = xm; xx <= xm + xr; xx++) begin
        if (xx < SW && yy < SH) begin
          xb  = xx[7:0];
          yb  = yy[7:0];
          old = ref_mem[xx][yy];
          nw  = raster(mode, xb, yb, old);
          ref_mem[xx][yy] = nw;
          exp_q.push_back((xx << 16) | (yy << 6) | (int'(old) << 3) | int'(nw));
          cycles += 3;
        end else begin
          cycles += 1;
        end
      end
    end
  endtask

  task automatic run_scan(input int xm, input int ym, input int xr, input int yr,
                          input int mode, input int hold, output int cyc, output int nwr);
    int model_cycles;
    int budget;
    int n;
    model_scan(xm, ym, xr, yr, mode, model_cycles);
    budget = model_cycles + 20;
    wq.delete();
    @(negedge clock);
    rast_mode   = mode;
    bus.x_min   = xm[7:0];
    bus.y_min   = ym[7:0];
    bus.x_range = xr[7:0];
    bus.y_range = yr[7:0];
    bus.start   = 1'b1;
    @(posedge clock);
    #1;
    cyc = 1;
    // Box inputs are scrambled once the scan has latched them.
    bus.x_min   = 8'($urandom);
    bus.y_min   = 8'($urandom);
    bus.x_range = 8'($urandom);
    bus.y_range = 8'($urandom);
    while (bus.done !== 1'b1 && cyc < budget) begin
      @(posedge clock);
      #1;
      cyc++;
    end
    check("done_latency", cyc, model_cycles);
    for (int h = 0; h < hold; h++) begin
      @(posedge clock);
      #1;
      check("done_held", int'(bus.done), 1);
    end
    @(negedge clock);
    bus.start = 1'b0;
    @(posedge clock);
    #1;
    check("done_drop", int'(bus.done), 0);
    nwr = wq.size();
    check("write_count", nwr, exp_q.size());
    n = (nwr < exp_q.size()) ? nwr : exp_q.size();
    for (int i = 0; i < n; i++) check("write_entry", wq[i], exp_q[i]);
  endtask

  typedef struct {
    int xm, ym, xr, yr;
    int mode;
    int hold;
    int exp_writes;
    int exp_cycles;
  } vec_t;

  vec_t tbl[6];

  initial begin
    int cyc;
    int nwr;
    int bad;
    int hx[6];
    int hy[6];
    int hd[6];

    vectors      = 0;
    miscompares  = 0;
    rast_mode    = 0;
    preload_req  = 1'b0;
    preload_sel  = 0;
    preload_seed = 0;
    reset        = 1'b1;
    bus.start    = 1'b0;
    bus.x_min    = '0;
    bus.y_min    = '0;
    bus.x_range  = '0;
    bus.y_range  = '0;

    tbl[0] = '{xm: 10,  ym: 20,  xr: 2,  yr: 1, mode: 0, hold: 0, exp_writes: 6,  exp_cycles: 19};
    tbl[1] = '{xm: 5,   ym: 5,   xr: 0,  yr: 0, mode: 0, hold: 3, exp_writes: 1,  exp_cycles: 4};
    tbl[2] = '{xm: 158, ym: 0,   xr: 3,  yr: 0, mode: 1, hold: 0, exp_writes: 2,  exp_cycles: 9};
    tbl[3] = '{xm: 250, ym: 0,   xr: 10, yr: 0, mode: 1, hold: 0, exp_writes: 0,  exp_cycles: 12};
    tbl[4] = '{xm: 0,   ym: 119, xr: 1,  yr: 1, mode: 1, hold: 0, exp_writes: 2,  exp_cycles: 9};
    tbl[5] = '{xm: 100, ym: 118, xr: 4,  yr: 3, mode: 0, hold: 0, exp_writes: 10, exp_cycles: 41};

    hx = '{10, 11, 12, 10, 11, 12};
    hy = '{20, 20, 20, 21, 21, 21};
    hd = '{1, 4, 1, 1, 4, 1};

    do_preload(0, 0);
    repeat (2) @(posedge clock);
    #1;
    check("reset_done",  int'(bus.done),  0);
    check("reset_we",    int'(bus.fb_we), 0);
    check("reset_x",     int'(bus.x),     0);
    check("reset_y",     int'(bus.y),     0);
    check("reset_fb_rx", int'(bus.fb_rx), 0);
    check("reset_fb_ry", int'(bus.fb_ry), 0);
    check("reset_fb_wx", int'(bus.fb_wx), 0);
    @(negedge clock);
    reset = 1'b0;

    for (int v = 0; v < 6; v++) begin
      run_scan(tbl[v].xm, tbl[v].ym, tbl[v].xr, tbl[v].yr, tbl[v].mode, tbl[v].hold, cyc, nwr);
      check("tbl_cycles", cyc, tbl[v].exp_cycles);
      check("tbl_writes", nwr, tbl[v].exp_writes);
      if (v == 0) begin
        for (int i = 0; i < 6; i++) begin
          if (i < wq.size()) begin
            check("box_wx",    (wq[i] >> 16) & 255, hx[i]);
            check("box_wy",    (wq[i] >> 6) & 1023, hy[i]);
            check("box_wdata", wq[i] & 7,           hd[i]);
          end else begin
            check("box_missing_write", i, 6);
          end
        end
      end
    end

    // Reset while the third pixel waits on memory.
    wq.delete();
    @(negedge clock);
    rast_mode   = 0;
    bus.x_min   = 8'd30;
    bus.y_min   = 8'd40;
    bus.x_range = 8'd2;
    bus.y_range = 8'd1;
    bus.start   = 1'b1;
    repeat (8) @(posedge clock);
    #1;
    check("abort_pre_writes", wq.size(), 2);
    check("abort_pre_fb_rx",  int'(bus.fb_rx), 32);
    @(negedge clock);
    reset     = 1'b1;
    bus.start = 1'b0;
    @(posedge clock);
    #1;
    check("abort_we",    int'(bus.fb_we), 0);
    check("abort_done",  int'(bus.done),  0);
    check("abort_x",     int'(bus.x),     0);
    check("abort_y",     int'(bus.y),     0);
    check("abort_fb_rx", int'(bus.fb_rx), 0);
    @(negedge clock);
    reset = 1'b0;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clock);
      #1;
      if (bus.fb_we !== 1'b0 || bus.done !== 1'b0) bad++;
    end
    check("abort_quiet",       bad,       0);
    check("abort_post_writes", wq.size(), 2);

    // Randomised boxes against the model, over a scrambled framebuffer.
    do_preload(1, int'($urandom_range(0, 7)));
    for (int r = 0; r < 25; r++) begin
      run_scan(int'($urandom_range(0, 255)), int'($urandom_range(0, 130)),
               int'($urandom_range(0, 5)),   int'($urandom_range(0, 3)),
               int'($urandom_range(0, 1)),   int'($urandom_range(0, 2)), cyc, nwr);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
